// File: rtl/tia_timing_pkg.sv
// Shared horizontal/vertical/object timing definitions: counter width,
// polynomial counter next-state function, phase encodings, default states.
// No ports; imported by tia_phase_gen and tia_hcount_seq.
package tia_timing_pkg;

  localparam int CNT_W = 6;
  typedef logic [CNT_W-1:0] hcnt_t;

  // Phase values whose following cycle carries the s1 / s2 strobe.
  localparam logic [1:0] PH_S1 = 2'd0;
  localparam logic [1:0] PH_S2 = 2'd2;

  localparam hcnt_t WRAP_DEFAULT  = 6'b010101;
  localparam hcnt_t MATCH_DEFAULT = 6'b111100;

  // XNOR-feedback shift: the all-zero state is legal, all-ones is the
  // lock-up state (it maps to itself).
  function automatic hcnt_t lfsr_next(input hcnt_t c);
    return {c[4:0], ~(c[5] ^ c[4])};
  endfunction

endpackage

// File: rtl/tia_phase_gen.sv
// Two-phase strobe generator: quarter-rate, non-overlapping s1/s2 plus the
// counter advance strobe (edge that ends the s2 cycle).
// Ports: clk, reset_n (sync, active-low), en (freeze when 0), s1, s2, adv.
module tia_phase_gen
  import tia_timing_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic s1,
  output logic s2,
  output logic adv
);

  logic [1:0] ph;
  logic [1:0] ph_nxt;

  assign ph_nxt = ph + 2'd1;

  // Combinational: the edge on which ph==PH_S2 is the one closing the s2 cycle.
  assign adv = en & (ph == PH_S2);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // ph=3 so that the first enabled edge lands on PH_S1.
      ph <= 2'd3;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      if (en) ph <= ph_nxt;
      s1 <= en & (ph_nxt == PH_S1);
      s2 <= en & (ph_nxt == PH_S2);
    end
  end

endmodule

// File: rtl/tia_hcount_seq.sv
// Horizontal counter sequencer: drives the D1/D2 phase strobes and advances
// the 6-bit polynomial counter once per 4 enabled clocks, with line wrap,
// software resync (RSYNC) and one programmable match decode.
// Ports: clk, reset_n, en, rsync in; s1, s2, count, wrap (registered),
// match (combinational from count) out.
module tia_hcount_seq
  import tia_timing_pkg::*;
#(
  parameter logic [5:0] WRAP_STATE  = WRAP_DEFAULT,
  parameter logic [5:0] MATCH_STATE = MATCH_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       rsync,
  output logic       s1,
  output logic       s2,
  output logic [5:0] count,
  output logic       wrap,
  output logic       match
);

  logic adv;
  logic rsync_pend;

  tia_phase_gen u_phase (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .s1      (s1),
    .s2      (s2),
    .adv     (adv)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count      <= '0;
      wrap       <= 1'b0;
      rsync_pend <= 1'b0;
    end else if (adv) begin
      if (rsync_pend || rsync) begin
        // Any number of strobes since the last advance collapse here.
        count      <= '0;
        wrap       <= 1'b1;
        rsync_pend <= 1'b0;
      end else if (count == WRAP_STATE) begin
        count <= '0;
        wrap  <= 1'b1;
      end else begin
        count <= lfsr_next(count);
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
      // Held across en=0 until the next advance edge.
      if (rsync) rsync_pend <= 1'b1;
    end
  end

  assign match = (count == MATCH_STATE);

endmodule

// File: tb/tb_tia_hcount_seq.sv
// Testbench for tia_hcount_seq: cycle model feeds a scoreboard queue at
// drive time; a monitor pops and compares after each rising edge.
// Scenario tasks add targeted checks for phase, pause, resync and reset.
module tb_tia_hcount_seq;

  localparam logic [5:0] WRAP_S  = 6'b010101;
  localparam logic [5:0] MATCH_S = 6'b111100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       rsync = 1'b0;
  logic       s1, s2, wrap, match;
  logic [5:0] count;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [1:0] m_ph = 2'd3;
  logic [5:0] m_cnt = '0;
  logic       m_pend = 1'b0;
  logic       m_s1 = 1'b0, m_s2 = 1'b0, m_wrap = 1'b0;

  logic [9:0] sb[$];

  tia_hcount_seq #(.WRAP_STATE(WRAP_S), .MATCH_STATE(MATCH_S)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .rsync   (rsync),
    .s1      (s1),
    .s2      (s2),
    .count   (count),
    .wrap    (wrap),
    .match   (match)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: compares DUT outputs against the queued expectation.
  always @(posedge clk) begin
    logic [9:0] exp_v;
    #1;
    if (sb.size() != 0) begin
      exp_v = sb.pop_front();
      tests++;
      if ({s1, s2, count, wrap, match} !== exp_v) begin
        fails++;
        $display("FAIL scoreboard t=%0t got s1s2_count_wrap_match=%b required %b",
                 $time, {s1, s2, count, wrap, match}, exp_v);
      end
    end
    if (s1 === 1'b1 && s2 === 1'b1) begin
      fails++;
      $display("FAIL overlap t=%0t s1 and s2 both high", $time);
    end
    if (count === 6'b111111) begin
      fails++;
      $display("FAIL lockup t=%0t count=111111", $time);
    end
  end

  // Apply one cycle of stimulus (called at the falling edge), advance the
  // model, queue the expected outputs, return at the next falling edge.
  task automatic drive(input logic e, input logic rs, input logic rn);
    logic [1:0] nph;
    logic       a;
    en = e; rsync = rs; reset_n = rn;
    if (!rn) begin
      m_ph = 2'd3; m_cnt = '0; m_pend = 1'b0;
      m_s1 = 1'b0; m_s2 = 1'b0; m_wrap = 1'b0;
    end else begin
      a    = e && (m_ph == 2'd2);
      nph  = m_ph + 2'd1;
      m_s1 = e && (nph == 2'd0);
      m_s2 = e && (nph == 2'd2);
      if (e) m_ph = nph;
      if (a) begin
        if (m_pend || rs) begin
          m_cnt = '0; m_pend = 1'b0; m_wrap = 1'b1;
        end else if (m_cnt == WRAP_S) begin
          m_cnt = '0; m_wrap = 1'b1;
        end else begin
          m_cnt = {m_cnt[4:0], ~(m_cnt[5] ^ m_cnt[4])};
          m_wrap = 1'b0;
        end
      end else begin
        m_wrap = 1'b0;
        if (rs) m_pend = 1'b1;
      end
    end
    sb.push_back({m_s1, m_s2, m_cnt, m_wrap, (m_cnt == MATCH_S)});
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run enabled until the model sits at (cnt, ph); bounded.
  task automatic run_to(input logic [5:0] c, input logic [1:0] p, input string nm);
    int n = 0;
    while (!(m_cnt == c && m_ph == p) && n < 400) begin
      drive(1'b1, 1'b0, 1'b1);
      n++;
    end
    tests++;
    if (!(m_cnt == c && m_ph == p)) begin
      fails++;
      $display("FAIL %s run_to: state %b/%0d not reached, at %b/%0d", nm, c, p, m_cnt, m_ph);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    tests++;
    if ({s1, s2, count, wrap, match} !== 10'b0) begin
      fails++;
      $display("FAIL reset_state got %b required 0", {s1, s2, count, wrap, match});
    end
    drive(1'b1, 1'b0, 1'b1);
    tests++;
    if ({s1, s2} !== 2'b10) begin
      fails++; $display("FAIL reset_edge1 s1s2 got %b required 10", {s1, s2});
    end
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    tests++;
    if ({s1, s2, count} !== {2'b01, 6'b000000}) begin
      fails++; $display("FAIL reset_edge3 s1s2/count got %b/%b required 01/000000", {s1, s2}, count);
    end
    drive(1'b1, 1'b0, 1'b1);
    tests++;
    if ({s1, s2, count} !== {2'b00, 6'b000001}) begin
      fails++; $display("FAIL reset_edge4 s1s2/count got %b/%b required 00/000001", {s1, s2}, count);
    end
  endtask

  task automatic test_free_run();
    int wraps = 0, mcyc = 0;
    logic [5:0] prev, pre_wrap = 6'bx;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 240; i++) begin
      prev = count;
      drive(1'b1, 1'b0, 1'b1);
      if (wrap === 1'b1) begin wraps++; pre_wrap = prev; end
      if (match === 1'b1) mcyc++;
    end
    tests++;
    if (wraps != 1) begin fails++; $display("FAIL free_run_wraps got %0d required 1", wraps); end
    tests++;
    if (pre_wrap !== WRAP_S) begin fails++; $display("FAIL free_run_prewrap got %b required %b", pre_wrap, WRAP_S); end
    tests++;
    if (mcyc != 4) begin fails++; $display("FAIL free_run_match_cycles got %0d required 4", mcyc); end
  endtask

  task automatic test_enable_pause();
    logic bad = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    run_to(6'b001111, 2'd1, "pause");
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      if (s1 !== 1'b0 || s2 !== 1'b0 || count !== 6'b001111) bad = 1'b1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL pause_hold s1/s2/count changed while en=0, last %b/%b/%b", s1, s2, count); end
    drive(1'b1, 1'b0, 1'b1);
    tests++;
    if ({s2, count} !== {1'b1, 6'b001111}) begin
      fails++; $display("FAIL pause_resume1 s2/count got %b/%b required 1/001111", s2, count);
    end
    drive(1'b1, 1'b0, 1'b1);
    tests++;
    if (count !== 6'b011111) begin fails++; $display("FAIL pause_resume2 count got %b required 011111", count); end
  endtask

  task automatic test_rsync();
    int wraps = 0;
    drive(1'b1, 1'b0, 1'b0);
    run_to(6'b011110, 2'd0, "rsync");
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    tests++;
    if ({count, wrap} !== {6'b000000, 1'b1}) begin
      fails++; $display("FAIL rsync_restart count/wrap got %b/%b required 000000/1", count, wrap);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1);
      if (wrap === 1'b1) wraps++;
    end
    tests++;
    if (count !== 6'b000001 || wraps != 0) begin
      fails++; $display("FAIL rsync_collapse count/wraps got %b/%0d required 000001/0", count, wraps);
    end
  endtask

  task automatic test_rsync_at_wrap();
    int wraps = 0;
    drive(1'b1, 1'b0, 1'b0);
    run_to(WRAP_S, 2'd2, "rsync_wrap");
    drive(1'b1, 1'b1, 1'b1);
    tests++;
    if ({count, wrap} !== {6'b000000, 1'b1}) begin
      fails++; $display("FAIL rsync_wrap_edge count/wrap got %b/%b required 000000/1", count, wrap);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1);
      if (wrap === 1'b1) wraps++;
    end
    tests++;
    if (count !== 6'b000001 || wraps != 0) begin
      fails++; $display("FAIL rsync_wrap_next count/wraps got %b/%0d required 000001/0", count, wraps);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0);
    run_to(6'b110011, 2'd2, "reset_mid");
    drive(1'b1, 1'b1, 1'b0);
    tests++;
    if ({s1, s2, count, wrap, match} !== 10'b0) begin
      fails++; $display("FAIL reset_mid_state got %b required 0", {s1, s2, count, wrap, match});
    end
    drive(1'b1, 1'b0, 1'b1);
    tests++;
    if ({s1, s2} !== 2'b10) begin fails++; $display("FAIL reset_mid_edge1 s1s2 got %b required 10", {s1, s2}); end
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    tests++;
    if (count !== 6'b000001) begin fails++; $display("FAIL reset_mid_edge4 count got %b required 000001", count); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_free_run();
    test_enable_pause();
    test_rsync();
    test_rsync_at_wrap();
    test_reset_mid();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
